// File: rtl/conv_pkg.sv
// Shared definitions for conv-layer controllers: sequencer states and
// output-dimension / counter-width helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CLR  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4,
    ST_FIN  = 3'd5
  } conv_state_e;

  // Number of window positions along one axis of the feature map.
  function automatic int out_dim(input int img, input int s, input int stride);
    return (img - s) / stride + 1;
  endfunction

  // Bits needed to index n positions; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_coord_counter.sv
// Two-dimensional raster counter over the output map: column runs fastest,
// row advances on column wrap, and last_o flags the final coordinate.
module conv_coord_counter #(
  parameter int OUT_W = 2,
  parameter int OUT_H = 2,
  parameter int CW    = 3,
  parameter int RW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(OUT_W - 1));
  assign row_end = (row_q == RW'(OUT_H - 1));

  // Raster step on each accepted advance; wraps to origin after the last point.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_end && row_end;

endmodule

// File: rtl/conv_window_sched.sv
// Window sequencer for one convUnit: requests each window in raster order,
// clears the unit, waits its fixed latency and hands the tagged result on.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int S          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = 1,
  parameter int CONV_LAT   = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        win_req,
  output logic [addr_w(IMG_H)-1:0]    win_row,
  output logic [addr_w(IMG_W)-1:0]    win_col,
  input  logic                        win_ack,
  output logic                        conv_rst,
  input  logic [DATA_WIDTH-1:0]       res_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [addr_w(IMG_H)-1:0]    out_row,
  output logic [addr_w(IMG_W)-1:0]    out_col
);

  localparam int OUT_W = out_dim(IMG_W, S, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, S, STRIDE);
  localparam int CW    = addr_w(IMG_W);
  localparam int RW    = addr_w(IMG_H);
  localparam int LW    = addr_w(CONV_LAT);

  conv_state_e           state_q;
  logic [LW-1:0]         lat_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  win_req_q;
  logic                  conv_rst_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [RW-1:0]         out_row_q;
  logic [CW-1:0]         out_col_q;

  logic [RW-1:0]         orow;
  logic [CW-1:0]         ocol;
  logic                  olast;
  logic                  coord_clr;
  logic                  coord_adv;

  assign coord_clr = (state_q == ST_IDLE) && start;
  assign coord_adv = (state_q == ST_OUT) && out_ready;

  conv_coord_counter #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .CW    (CW),
    .RW    (RW)
  ) u_coord (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (coord_clr),
    .adv_i  (coord_adv),
    .row_o  (orow),
    .col_o  (ocol),
    .last_o (olast)
  );

  // Sequencer FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_req_q   <= 1'b0;
      conv_rst_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          conv_rst_q <= 1'b1;
          if (start) begin
            state_q    <= ST_REQ;
            busy_q     <= 1'b1;
            win_req_q  <= 1'b1;
            conv_rst_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (win_ack) begin
            state_q    <= ST_CLR;
            win_req_q  <= 1'b0;
            conv_rst_q <= 1'b1;
          end
        end
        ST_CLR: begin
          state_q    <= ST_WAIT;
          conv_rst_q <= 1'b0;
          lat_q      <= '0;
        end
        ST_WAIT: begin
          if (lat_q == LW'(CONV_LAT - 1)) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= res_in;
            out_row_q   <= orow;
            out_col_q   <= ocol;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (olast) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              win_req_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          conv_rst_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          win_req_q   <= 1'b0;
          conv_rst_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_req   = win_req_q;
  assign win_row   = RW'(orow * STRIDE);
  assign win_col   = CW'(ocol * STRIDE);
  assign conv_rst  = conv_rst_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench: a 6x6/S5/stride-1 sequencer (2x2 outputs) and a
// 9x9/S5/stride-2 sequencer (3x3 outputs).
module tb_conv_window_sched;

  localparam logic [15:0] RES1 = 16'h5C80;
  localparam logic [15:0] RES2 = 16'h1234;

  logic clk;
  logic rst;

  // Instance 1 signals
  logic        start, busy, done, win_req, win_ack, conv_rst;
  logic [2:0]  win_row, win_col, out_row, out_col;
  logic [15:0] res_in, out_data;
  logic        out_valid, out_ready;

  // Instance 2 signals
  logic        start2, busy2, done2, win_req2, win_ack2, conv_rst2;
  logic [3:0]  win_row2, win_col2, out_row2, out_col2;
  logic [15:0] res_in2, out_data2;
  logic        out_valid2, out_ready2;

  int n_cmp;
  int n_err;

  conv_window_sched #(
    .DATA_WIDTH(16), .S(5), .IMG_W(6), .IMG_H(6), .STRIDE(1), .CONV_LAT(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
    .conv_rst(conv_rst), .res_in(res_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col)
  );

  conv_window_sched #(
    .DATA_WIDTH(16), .S(5), .IMG_W(9), .IMG_H(9), .STRIDE(2), .CONV_LAT(20)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .win_req(win_req2), .win_row(win_row2), .win_col(win_col2), .win_ack(win_ack2),
    .conv_rst(conv_rst2), .res_in(res_in2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_row(out_row2), .out_col(out_col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One window on instance 1: REQ at cycle t, CLR at t+1, out_valid at t+22.
  task automatic do_window(input int r, input int c, input int bp, input bit poke, input bit last);
    int k;
    int bad;
    k = 0;
    while (!win_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("win_req_seen", {31'd0, win_req}, 32'd1);
    check_eq("win_row", {29'd0, win_row}, r);
    check_eq("win_col", {29'd0, win_col}, c);
    check_eq("crst_in_req", {31'd0, conv_rst}, 32'd0);
    check_eq("busy_in_pass", {31'd0, busy}, 32'd1);
    out_ready = (bp == 0);
    win_ack = 1'b1;
    if (poke) start = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
    start = 1'b0;
    check_eq("crst_clr", {31'd0, conv_rst}, 32'd1);
    check_eq("req_drop", {31'd0, win_req}, 32'd0);
    bad = 0;
    for (int i = 2; i < 22; i++) begin
      @(negedge clk);
      if (out_valid || conv_rst || win_req) bad++;
    end
    check_eq("wait_quiet", bad, 0);
    @(negedge clk);
    check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
    check_eq("out_data", {16'd0, out_data}, {16'd0, RES1});
    check_eq("out_row", {29'd0, out_row}, r);
    check_eq("out_col", {29'd0, out_col}, c);
    bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!out_valid || out_data != RES1 || out_row != 3'(r) || out_col != 3'(c) || win_req)
        bad++;
    end
    check_eq("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("valid_drop", {31'd0, out_valid}, 32'd0);
    check_eq("done_flag", {31'd0, done}, {31'd0, last});
    check_eq("next_req", {31'd0, win_req}, {31'd0, !last});
  endtask

  task automatic start_pass1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0; win_ack = 1'b0; out_ready = 1'b0; res_in = RES1;
    start2 = 1'b0; win_ack2 = 1'b0; out_ready2 = 1'b1; res_in2 = RES2;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_req", {31'd0, win_req}, 32'd0);
    check_eq("rst_crst", {31'd0, conv_rst}, 32'd1);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {16'd0, out_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Pass A: immediate ack, ready always high.
    start_pass1();
    do_window(0, 0, 0, 1'b0, 1'b0);
    do_window(0, 1, 0, 1'b0, 1'b0);
    do_window(1, 0, 0, 1'b0, 1'b0);
    do_window(1, 1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("done_pulse_end", {31'd0, done}, 32'd0);
    check_eq("busy_end", {31'd0, busy}, 32'd0);

    // Pass B: backpressure on window 0, start poked while busy and in FIN.
    start_pass1();
    do_window(0, 0, 7, 1'b0, 1'b0);
    do_window(0, 1, 0, 1'b1, 1'b0);
    do_window(1, 0, 0, 1'b0, 1'b0);
    do_window(1, 1, 0, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("fin_done_drop", {31'd0, done}, 32'd0);
    check_eq("fin_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("fin_start_ign_req", {31'd0, win_req}, 32'd0);
    check_eq("fin_start_ign_busy", {31'd0, busy}, 32'd0);

    // Pass C: fresh start from IDLE restarts at (0,0); then reset mid-WAIT of window 1.
    start_pass1();
    do_window(0, 0, 0, 1'b0, 1'b0);
    win_ack = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_crst", {31'd0, conv_rst}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_col", {29'd0, win_col}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req", {31'd0, win_req}, 32'd0);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

    // Stride-2 instance: 3x3 outputs, windows at 0,2,4.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        k = 0;
        while (!win_req2 && k < 50) begin
          @(negedge clk);
          k++;
        end
        check_eq("s2_req_seen", {31'd0, win_req2}, 32'd1);
        check_eq("s2_win_row", {28'd0, win_row2}, 2 * r);
        check_eq("s2_win_col", {28'd0, win_col2}, 2 * c);
        win_ack2 = 1'b1;
        @(negedge clk);
        win_ack2 = 1'b0;
        k = 0;
        while (!out_valid2 && k < 50) begin
          @(negedge clk);
          k++;
        end
        check_eq("s2_valid", {31'd0, out_valid2}, 32'd1);
        check_eq("s2_data", {16'd0, out_data2}, {16'd0, RES2});
        check_eq("s2_row", {28'd0, out_row2}, r);
        check_eq("s2_col", {28'd0, out_col2}, c);
        @(negedge clk);
        check_eq("s2_done", {31'd0, done2}, (r == 2 && c == 2) ? 32'd1 : 32'd0);
      end
    end
    @(negedge clk);
    check_eq("s2_busy_end", {31'd0, busy2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
